traffic_phase_sequencer: RTL

//  Parametrised successor to the fixed 5-light intersection controller.

---
 rtl/traffic_phase_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer
//   Demand-driven round-robin phase sequencer for NUM_LIGHTS movement lights.
//   Each phase group is a bitmask of lights that may be green together. The
//   sequencer serves one group at a time through GREEN -> YELLOW -> ALLRED.
//   It enforces a minimum green time and a maximum green time when other
//   groups have demand, and it has a night flash mode.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous, active-low reset
//   sensor       : per-light demand; bit i pairs with light i
//   flash_en     : request night flash mode
//   light        : 2 bits per light, light i at [2i+1:2i]
//                  red=00, yellow=01, green=10
//   active_group : group being served; the last group served when idle or flashing
//   phase_state  : IDLE=0 GREEN=1 YELLOW=2 ALLRED=3 FLASH=4
// ---------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int NUM_LIGHTS   = 5,
  parameter int NUM_GROUPS   = 5,
  parameter logic [NUM_GROUPS-1:0][NUM_LIGHTS-1:0] GROUP_MASK =
    {5'b10000, 5'b00101, 5'b01100, 5'b00011, 5'b01010},
  parameter int GREEN_MIN    = 3,
  parameter int GREEN_MAX    = 8,
  parameter int YELLOW_TIME  = 2,
  parameter int ALLRED_TIME  = 1,
  parameter int FLASH_PERIOD = 4,
  localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_LIGHTS-1:0]   sensor,
  input  logic                    flash_en,
  output logic [2*NUM_LIGHTS-1:0] light,
  output logic [GRP_W-1:0]        active_group,
  output logic [2:0]              phase_state
);

  // One counter serves every timed phase, so it is sized for the longest phase.
  localparam int MAX_T = (GREEN_MAX >= YELLOW_TIME && GREEN_MAX >= ALLRED_TIME &&
                          GREEN_MAX >= FLASH_PERIOD) ? GREEN_MAX :
                         (YELLOW_TIME >= ALLRED_TIME && YELLOW_TIME >= FLASH_PERIOD) ? YELLOW_TIME :
                         (ALLRED_TIME >= FLASH_PERIOD) ? ALLRED_TIME : FLASH_PERIOD;
  localparam int CNT_W = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] FP_M1   = CNT_W'(FLASH_PERIOD - 1);

  localparam logic [1:0] C_RED    = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_ALLRED = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [GRP_W-1:0] group_q, group_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_yel_q, flash_yel_d;

  logic [NUM_GROUPS-1:0] demand;
  logic [NUM_GROUPS-1:0] cur_oh;
  logic                  own;
  logic                  other;
  logic                  any_demand;
  logic                  sel_found;
  logic [GRP_W-1:0]      sel_group;

  // Demand per group and the round-robin pick. The scan starts just after
  // the last served group and wraps back to that group, so a group that is
  // the only one with demand is picked again.
  always_comb begin
    demand    = '0;
    sel_found = 1'b0;
    sel_group = group_q;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      demand[g] = |(sensor & GROUP_MASK[g]);
    end
    for (int k = 1; k <= NUM_GROUPS; k++) begin
      if (!sel_found && demand[(int'(group_q) + k) % NUM_GROUPS]) begin
        sel_found = 1'b1;
        sel_group = GRP_W'((int'(group_q) + k) % NUM_GROUPS);
      end
    end
    cur_oh     = NUM_GROUPS'(1) << group_q;
    own        = |(demand & cur_oh);
    other      = |(demand & ~cur_oh);
    any_demand = |demand;
  end

  always_comb begin
    state_d     = state_q;
    group_d     = group_q;
    cnt_d       = cnt_q;
    flash_yel_d = flash_yel_q;
    case (state_q)
      S_IDLE: begin
        if (flash_en) begin
          state_d     = S_FLASH;
          cnt_d       = '0;
          flash_yel_d = 1'b1;
        end else if (any_demand) begin
          state_d = S_GREEN;
          group_d = sel_group;
          cnt_d   = '0;
        end
      end
      S_GREEN: begin
        // The group stays green with no competing demand, even after its own
        // demand drops. It only yields after min green.
        if (cnt_q >= GMIN_M1 && (flash_en || (other && (!own || cnt_q >= GMAX_M1)))) begin
          state_d = S_YELLOW;
          cnt_d   = '0;
        end else if (cnt_q < GMAX_M1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_YELLOW: begin
        if (cnt_q == YEL_M1) begin
          state_d = S_ALLRED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ALLRED: begin
        if (cnt_q == AR_M1) begin
          cnt_d = '0;
          if (flash_en) begin
            state_d     = S_FLASH;
            flash_yel_d = 1'b1;
          end else if (any_demand) begin
            state_d = S_GREEN;
            group_d = sel_group;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLASH: begin
        if (!flash_en) begin
          state_d = S_ALLRED;
          cnt_d   = '0;
        end else if (cnt_q == FP_M1) begin
          cnt_d       = '0;
          flash_yel_d = !flash_yel_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      group_q     <= GRP_W'(NUM_GROUPS - 1);
      cnt_q       <= '0;
      flash_yel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      group_q     <= group_d;
      cnt_q       <= cnt_d;
      flash_yel_q <= flash_yel_d;
    end
  end

  // The light decode is taken straight from the registered state. An async
  // reset therefore turns every light red without waiting for a clock edge.
  always_comb begin
    light = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      light[2*i +: 2] = C_RED;
      case (state_q)
        S_GREEN:  if (GROUP_MASK[group_q][i]) light[2*i +: 2] = C_GREEN;
        S_YELLOW: if (GROUP_MASK[group_q][i]) light[2*i +: 2] = C_YELLOW;
        S_FLASH:  light[2*i +: 2] = flash_yel_q ? C_YELLOW : C_RED;
        default:  light[2*i +: 2] = C_RED;
      endcase
    end
  end

  assign active_group = group_q;
  assign phase_state  = state_q;

endmodule
